// File: rtl/row_ifilter.sv
// Inverse 9/7 lifting row filter: one (low, high) coefficient pair per advance, even/odd samples out.
// Define ROW_IFILTER_SAT_EN to saturate outputs to 16 bits; otherwise the low 16 bits are kept.
module row_ifilter #(
  parameter int SCALE_L = 10078,
  parameter int SCALE_H = 6659,
  parameter int ALPHA   = 12994,
  parameter int BETA    = 434,
  parameter int GAMMA   = 7233,
  parameter int DELTA   = 3633
) (
  input  logic        clk_rf,
  input  logic        rst_syn,
  input  logic        idwt_work,
  input  logic [2:0]  level,
  input  logic [15:0] row_ldata,
  input  logic [15:0] row_hdata,
  input  logic        row_in_vld,
  output logic        row_in_rdy,
  output logic [15:0] rec_even,
  output logic [15:0] rec_odd,
  output logic        rec_out_vld,
  output logic        irf_over
);

  typedef enum logic [1:0] {IDLE, RECV, FL1, FL2} state_t;

  state_t state_q, state_d;
  logic [2:0] level_q, level_d;
  logic [6:0] pair_q, pair_d;
  logic [6:0] row_q, row_d;
  logic signed [19:0] d0_q, s1_q, d1_q, s2_q;
  logic [15:0] even_q, odd_q;
  logic vld_q, over_q;

  function automatic logic signed [20:0] add21(input logic signed [19:0] a,
                                               input logic signed [19:0] b);
    return {a[19], a} + {b[19], b};
  endfunction

  function automatic logic signed [19:0] lift(input logic signed [20:0] x,
                                              input logic signed [15:0] c);
    logic signed [36:0] prod;
    prod = x * c;
    return 20'(prod >>> 13);
  endfunction

  function automatic logic [15:0] toOut(input logic signed [19:0] v);
`ifdef ROW_IFILTER_SAT_EN
    if (v > 20'sd32767) return 16'h7fff;
    if (v < -20'sd32768) return 16'h8000;
`endif
    return 16'(v);
  endfunction

  logic [7:0] pCnt;
  logic [6:0] pLast, rLast;
  logic xfer, advance, firstAdv, secondAdv, emit, isFl1, isFl2;
  logic signed [19:0] s0n, d0n, s1n, d1n, s2n, d2n;

  assign pCnt  = 8'd64 >> level_q;
  assign pLast = 7'(pCnt - 8'd1);
  assign rLast = 7'((pCnt << 1) - 8'd1);

  assign isFl1      = (state_q == FL1);
  assign isFl2      = (state_q == FL2);
  assign row_in_rdy = idwt_work && !rst_syn &&
                      (((state_q == IDLE) && (level <= 3'd4)) || (state_q == RECV));
  assign xfer       = row_in_rdy && row_in_vld;
  assign advance    = xfer || (idwt_work && (isFl1 || isFl2));
  assign firstAdv   = (state_q == IDLE) || ((state_q == RECV) && (pair_q == 7'd0));
  assign secondAdv  = (state_q == RECV) && (pair_q == 7'd1);
  assign emit       = ((state_q == RECV) && (pair_q >= 7'd2)) || isFl1 || isFl2;

  // One lifting step per stage; the left-edge mirrors replace the missing previous neighbour
  // and the flush states replay the last even sample as its own right neighbour.
  always_comb begin
    s0n = lift($signed({row_ldata[15], row_ldata, 4'b0}) >>> 4, 16'(SCALE_L));
    d0n = lift($signed({row_hdata[15], row_hdata, 4'b0}) >>> 4, 16'(SCALE_H));
    s1n = (isFl1 || isFl2) ? s1_q
                           : s0n - lift(add21(firstAdv ? d0n : d0_q, d0n), 16'(DELTA));
    d1n = d0_q - lift(add21(s1_q, s1n), 16'(GAMMA));
    s2n = isFl2 ? s2_q
                : s1_q + lift(add21(secondAdv ? d1n : d1_q, d1n), 16'(BETA));
    d2n = d1_q + lift(add21(s2_q, s2n), 16'(ALPHA));
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    pair_d  = pair_q;
    row_d   = row_q;
    case (state_q)
      IDLE: if (xfer) begin
        level_d = level;
        pair_d  = 7'd1;
        state_d = RECV;
      end
      RECV: if (xfer) begin
        pair_d = pair_q + 7'd1;
        if (pair_q == pLast) state_d = FL1;
      end
      FL1: if (idwt_work) state_d = FL2;
      FL2: if (idwt_work) begin
        pair_d = 7'd0;
        if (row_q == rLast) begin
          row_d   = 7'd0;
          state_d = IDLE;
        end else begin
          row_d   = row_q + 7'd1;
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pipeline registers are cleared at the end of every row so nothing leaks across rows.
  always_ff @(posedge clk_rf) begin
    if (rst_syn) begin
      state_q <= IDLE;
      level_q <= 3'd0;
      pair_q  <= 7'd0;
      row_q   <= 7'd0;
      d0_q    <= '0;
      s1_q    <= '0;
      d1_q    <= '0;
      s2_q    <= '0;
      even_q  <= '0;
      odd_q   <= '0;
      vld_q   <= 1'b0;
      over_q  <= 1'b0;
    end else if (idwt_work) begin
      state_q <= state_d;
      level_q <= level_d;
      pair_q  <= pair_d;
      row_q   <= row_d;
      vld_q   <= advance && emit;
      over_q  <= advance && isFl2 && (row_q == rLast);
      if (advance) begin
        if (isFl2) begin
          d0_q <= '0;
          s1_q <= '0;
          d1_q <= '0;
          s2_q <= '0;
        end else begin
          d0_q <= d0n;
          s1_q <= s1n;
          d1_q <= d1n;
          s2_q <= s2n;
        end
        if (emit) begin
          even_q <= toOut(s2_q);
          odd_q  <= toOut(d2n);
        end
      end
    end
  end

  assign rec_even    = even_q;
  assign rec_odd     = odd_q;
  assign rec_out_vld = vld_q && idwt_work;
  assign irf_over    = over_q && idwt_work;

endmodule

// File: doc/row_ifilter.md
# row_ifilter

Inverse 9/7 lifting row filter for the IDWT path. Takes one low/high coefficient pair per accepted beat, one row of a subband tile at a time, and reconstructs interleaved even/odd samples using symmetric boundary extension. It is the synthesis counterpart of the forward row filter and feeds the inverse column stage.

## Interface
Parameters:
- SCALE_L, 10078: Q13 inverse scale applied to low input (1.230174).
- SCALE_H, 6659: Q13 inverse scale applied to high input (0.812893).
- ALPHA, 12994: Q13 |α| (1.586134).
- BETA, 434: Q13 |β| (0.052980).
- GAMMA, 7233: Q13 γ (0.882911).
- DELTA, 3633: Q13 δ (0.443507).

Ports:
- clk_rf, in, 1: the only clock.
- rst_syn, in, 1: synchronous, active-high reset.
- idwt_work, in, 1: global enable. When low, all state freezes and row_in_rdy=0.
- level, in, 3: decomposition level 0..4. Pairs per row P=64>>level; rows per pass R=2P. Values 5..7 are invalid: rdy stays 0.
- row_ldata, in, 16: signed low coefficient s[n].
- row_hdata, in, 16: signed high coefficient d[n].
- row_in_vld, in, 1: input pair valid.
- row_in_rdy, out, 1: block can accept a pair.
- rec_even, out, 16: reconstructed x[2n].
- rec_odd, out, 16: reconstructed x[2n+1].
- rec_out_vld, out, 1: one-cycle strobe per output pair.
- irf_over, out, 1: pass complete. Coincides with the last rec_out_vld.

## Operation
- Transfer occurs when row_in_vld && row_in_rdy && idwt_work.
- FSM states:
  - IDLE (rdy=1): on transfer, latch level, pair_cnt=1, go to RECV.
  - RECV (rdy=1): each transfer increments pair_cnt. On the transfer with pair_cnt==P-1, go to FL1.
  - FL1 (rdy=0): one cycle, then go to FL2.
  - FL2 (rdy=0): if row_cnt==R-1, go to IDLE and clear counters. Otherwise increment row_cnt and go to RECV with pair_cnt=0.
- The pipeline advances only on an advance event: a transfer, or a cycle in FL1 or FL2.
- Arithmetic: signed, 20-bit internal. Each product is computed at full precision, then arithmetic shift right by 13 (floor).
  - s0 = (L·SCALE_L)>>>13, d0 = (H·SCALE_H)>>>13
  - s1[n] = s0[n] − (DELTA·(d0[n−1]+d0[n]))>>>13
  - d1[n] = d0[n] − (GAMMA·(s1[n]+s1[n+1]))>>>13
  - s2[n] = s1[n] + (BETA·(d1[n−1]+d1[n]))>>>13
  - d2[n] = d1[n] + (ALPHA·(s2[n]+s2[n+1]))>>>13
  - rec_even = s2[n], rec_odd = d2[n], truncated to bits [15:0].
- Boundaries are mirrored per row: d0[−1]=d0[0] and d1[−1]=d1[0]; s1[P]=s1[P−1] and s2[P]=s2[P−1]. FL1 and FL2 supply these right-edge mirrors.
- Neighbour registers are re-initialised at each row start, so no data crosses a row boundary.
- Output pair n depends on input pair n+2, or on a flush advance for n ≥ P−2.

## Timing
- Reset values: row_in_rdy=0 during the rst_syn cycle, then 1 in IDLE. rec_even=0, rec_odd=0, rec_out_vld=0, irf_over=0. State is IDLE; all counters and pipeline registers are 0.
- Latency: output pair n is registered and visible on the cycle after the advance that completes its dependency (third advance onward).
- Each row gives exactly P rec_out_vld pulses. P+2 advances are needed per row; the minimum row period is P+2 cycles.
- Gaps (row_in_vld low during RECV) stall the pipeline. No outputs are produced during a gap and data is not corrupted.
- irf_over pulses for one cycle with the final pair of row R−1.
- rst_syn mid-row: the row is discarded and the next cycle is in the reset state. rst_syn has priority over idwt_work.
- idwt_work low: all state, including outputs, holds. A strobe already visible holds too; rec_out_vld is gated low while idwt_work=0.
- Changes to level outside IDLE are ignored.

## Configuration
- ROW_IFILTER_SAT_EN defined: rec_even and rec_odd saturate the 20-bit results to [−32768, 32767].
- ROW_IFILTER_SAT_EN undefined: the output is the low 16 bits (wrap).

## Test plan
- Level 4, all pairs (0,0): 4 strobes per row over 8 rows; all outputs 0; irf_over once with the 32nd strobe.
- Level 4, L=100, H=0 every pair: every rec_even=100 and rec_odd=100 (s0=123, d1=−217, s2=100, d2=100).
- Level 3, row_in_vld held high: row_in_rdy drops for exactly 2 cycles after pair 7 of each row, and no extra pair is accepted. Outputs match the gapless golden model.
- Level 4, row_in_vld low for 3 cycles before pair 2: output values are unchanged versus the gapless run; strobes for pairs 0..1 are shifted 3 cycles later.
- Level 2, rst_syn on pair 5 of row 3: the next cycle shows all outputs 0 and the IDLE state. A following full pass matches the golden model from row 0.
- L=32000, H=−32000 alternating, level 4: with ROW_IFILTER_SAT_EN, any overflowing sample equals 32767 or −32768. Without it, outputs equal the golden model's 20-bit result [15:0].
